// File: rtl/lab6_pkg.sv
// rtl/lab6_pkg.sv - shared constants, field positions and FSM states for the lab6 front end
//
// Purpose: opcode constants, register-file indices, instruction field bit
//          positions and the issue-FSM state type used by mul_issue_ctrl and
//          regfile4x8.
// Ports:   none (package).
package lab6_pkg;

  localparam logic [3:0] OP_LDI    = 4'b0001;
  localparam logic [3:0] OP_MUL    = 4'b1010;
  localparam logic [3:0] CTRL_IDLE = 4'b0000;

  localparam logic [1:0] REG_RX = 2'd0;
  localparam logic [1:0] REG_RY = 2'd1;
  localparam logic [1:0] REG_RZ = 2'd2;
  localparam logic [1:0] REG_RT = 2'd3;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 8;
  localparam int RS2_HI = 7;
  localparam int RS2_LO = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_PULSE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/regfile4x8.sv
// rtl/regfile4x8.sv - 4x8 register file, one write port, four always-visible outputs
//
// Purpose: holds RX..RT. Asynchronous active-high reset clears all entries.
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous active-high reset
//   we_i     in   1  write enable
//   waddr_i  in   2  write index (REG_RX..REG_RT)
//   wdata_i  in   8  write data
//   rx_o..rt_o out 8 registered contents of each entry
module regfile4x8
  import lab6_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rx_o,
  output logic [7:0] ry_o,
  output logic [7:0] rz_o,
  output logic [7:0] rt_o
);

  logic [7:0] mem_q [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rx_o = mem_q[REG_RX];
  assign ry_o = mem_q[REG_RY];
  assign rz_o = mem_q[REG_RZ];
  assign rt_o = mem_q[REG_RT];

endmodule

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - instruction front end driving the 8x8 shift-add multiplier
//
// Purpose: accepts 16-bit instructions on a valid/ready handshake, executes LDI
//          directly into the register file and sequences MUL through
//          IDLE -> ISSUE -> PULSE -> WAIT(MUL_WAIT) -> IDLE, capturing the
//          multiplier product and writing it back to rd.
// Build option: MUL_SAT_WB_EN - when defined, MUL write-back saturates to 8'hFF
//          if the product's upper byte is non-zero; otherwise it truncates.
// Parameters:
//   MUL_WAIT   cycles between the calculate pulse and product capture (>=1)
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid/instr        instruction handshake input ([15:12] op, [11:10] rd,
//                            [9:8] rs1, [7:6] rs2, [7:0] imm)
//   instr_ready              high only in IDLE
//   RX,RY,RZ,RT              register file contents
//   controll                 4'b1010 while a MUL is in flight, else 0
//   outreg1/outreg2          rs1/rs2 selects to the multiplier
//   calculate                one-cycle multiplier trigger
//   product_in               multiplier product
//   result/result_valid      last captured product and its one-cycle strobe
//   busy                     high outside IDLE
module mul_issue_ctrl
  import lab6_pkg::*;
#(
  parameter int MUL_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [7:0]  RX,
  output logic [7:0]  RY,
  output logic [7:0]  RZ,
  output logic [7:0]  RT,
  output logic [3:0]  controll,
  output logic [1:0]  outreg1,
  output logic [1:0]  outreg2,
  output logic        calculate,
  input  logic [15:0] product_in,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  rd_q, rd_d;
  logic [1:0]  sel1_q, sel1_d;
  logic [1:0]  sel2_q, sel2_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [15:0] result_q, result_d;
  logic        rvalid_q, rvalid_d;

  logic        accept;
  logic        capture;
  logic [3:0]  op;
  logic [7:0]  wb_byte;
  logic        rf_we;
  logic [1:0]  rf_waddr;
  logic [7:0]  rf_wdata;

  assign op     = instr[OP_HI:OP_LO];
  assign accept = instr_valid && (state_q == ST_IDLE);

`ifdef MUL_SAT_WB_EN
  assign wb_byte = (product_in[15:8] != 8'h00) ? 8'hFF : product_in[7:0];
`else
  assign wb_byte = product_in[7:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      sel1_q   <= '0;
      sel2_q   <= '0;
      ctrl_q   <= CTRL_IDLE;
      result_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      sel1_q   <= sel1_d;
      sel2_q   <= sel2_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    sel1_d   = sel1_q;
    sel2_d   = sel2_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    rvalid_d = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // LDI and NOPs complete in IDLE; only MUL leaves it.
        if (accept && op == OP_MUL) begin
          rd_d    = instr[RD_HI:RD_LO];
          sel1_d  = instr[RS1_HI:RS1_LO];
          sel2_d  = instr[RS2_HI:RS2_LO];
          ctrl_d  = OP_MUL;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        cnt_d   = 8'(MUL_WAIT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 8'd0) begin
          capture  = 1'b1;
          result_d = product_in;
          rvalid_d = 1'b1;
          ctrl_d   = CTRL_IDLE;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture and LDI accept never coincide: capture happens in WAIT, accept only in IDLE.
  assign rf_we    = capture || (accept && op == OP_LDI);
  assign rf_waddr = capture ? rd_q : instr[RD_HI:RD_LO];
  assign rf_wdata = capture ? wb_byte : instr[IMM_HI:IMM_LO];

  regfile4x8 u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (rf_we),
    .waddr_i (rf_waddr),
    .wdata_i (rf_wdata),
    .rx_o    (RX),
    .ry_o    (RY),
    .rz_o    (RZ),
    .rt_o    (RT)
  );

  // Decoded from the registered state, so these clear immediately on async reset.
  assign instr_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign calculate    = (state_q == ST_PULSE);
  assign controll     = ctrl_q;
  assign outreg1      = sel1_q;
  assign outreg2      = sel2_q;
  assign result       = result_q;
  assign result_valid = rvalid_q;

endmodule
